// File: rtl/servo_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// servo_ramp_ctrl_if
//
// Purpose : command channel between the motion/command sequencer and
//           servo_ramp_ctrl.  It carries one direction command per transfer
//           with a valid/ready handshake, plus a one-cycle error pulse that
//           flags commands addressed to a channel the controller does not have.
//
// Parameters:
//   CH_W       width of the channel-select field
//
// Signals:
//   cmd_valid  sequencer -> ctrl   a command is present
//   cmd_ready  ctrl -> sequencer   the command can be accepted this cycle
//   cmd_ch     sequencer -> ctrl   target channel index
//   cmd_dir    sequencer -> ctrl   requested direction (SERVO_DIR_* encoding)
//   cmd_err    ctrl -> sequencer   one-cycle pulse: accepted cmd_ch out of range
//
// Modports:
//   master     sequencer side
//   slave      servo_ramp_ctrl side
//
// Build-time defaults for the servo constants live here and in the design file
// so that either file can be compiled first.
// -----------------------------------------------------------------------------
`ifndef SERVO_PWM_BITS
`define SERVO_PWM_BITS 8
`endif
`ifndef SERVO_PWM_UP
`define SERVO_PWM_UP 15
`endif
`ifndef SERVO_PWM_DOWN
`define SERVO_PWM_DOWN 5
`endif
`ifndef SERVO_PWM_CENTER
`define SERVO_PWM_CENTER 10
`endif
`ifndef SERVO_DIR_STAY
`define SERVO_DIR_STAY 2'd0
`endif
`ifndef SERVO_DIR_UP
`define SERVO_DIR_UP 2'd1
`endif
`ifndef SERVO_DIR_DOWN
`define SERVO_DIR_DOWN 2'd2
`endif

interface servo_ramp_ctrl_if #(
   parameter int CH_W = 1
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [CH_W-1:0] cmd_ch;
   logic [1:0]      cmd_dir;
   logic            cmd_err;

   modport master (
      output cmd_valid,
      output cmd_ch,
      output cmd_dir,
      input  cmd_ready,
      input  cmd_err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_ch,
      input  cmd_dir,
      output cmd_ready,
      output cmd_err
   );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// servo_ramp_ctrl
//
// Purpose : multi-channel servo PWM generator.  Direction commands (UP / DOWN /
//           STAY) arrive over a valid/ready channel and set a per-channel
//           on-time target.  A shared period counter times the PWM frame; once
//           per frame (on wrap) each channel's live on-time moves toward its
//           target, so a frame never mixes two on-times and the servos move
//           smoothly.
//
// Build option:
//   SERVO_RAMP_EN  defined   : on each wrap cur steps toward tgt by STEP,
//                              clamped at tgt (slewing).
//                  undefined : on each wrap cur jumps straight to tgt; STEP
//                              has no effect.
//
// Parameters:
//   NUM_CH     number of servo channels (1..8)
//   CH_W       width of the channel-select field (default: enough for NUM_CH)
//   PWM_BITS   width of the period counter and on-time values
//   PERIOD     PWM frame length in ticks (2..2^PWM_BITS)
//   ON_UP      on-time target for SERVO_DIR_UP
//   ON_DOWN    on-time target for SERVO_DIR_DOWN
//   ON_CENTER  on-time target for SERVO_DIR_STAY, unknown codes and reset
//   STEP       on-time change per frame while slewing (>= 1)
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset
//   tick       time-base enable; the frame counter advances only when high
//   cmd        command channel (servo_ramp_ctrl_if.slave)
//   pwm_out    registered PWM outputs, one per channel
//   settled    per channel: live on-time equals its target
// -----------------------------------------------------------------------------
`ifndef SERVO_PWM_BITS
`define SERVO_PWM_BITS 8
`endif
`ifndef SERVO_PWM_UP
`define SERVO_PWM_UP 15
`endif
`ifndef SERVO_PWM_DOWN
`define SERVO_PWM_DOWN 5
`endif
`ifndef SERVO_PWM_CENTER
`define SERVO_PWM_CENTER 10
`endif
`ifndef SERVO_DIR_STAY
`define SERVO_DIR_STAY 2'd0
`endif
`ifndef SERVO_DIR_UP
`define SERVO_DIR_UP 2'd1
`endif
`ifndef SERVO_DIR_DOWN
`define SERVO_DIR_DOWN 2'd2
`endif

module servo_ramp_ctrl #(
   parameter int NUM_CH    = 2,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int PWM_BITS  = `SERVO_PWM_BITS,
   parameter int PERIOD    = 20,
   parameter int ON_UP     = `SERVO_PWM_UP,
   parameter int ON_DOWN   = `SERVO_PWM_DOWN,
   parameter int ON_CENTER = `SERVO_PWM_CENTER,
   parameter int STEP      = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   servo_ramp_ctrl_if.slave  cmd,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] settled
);

   localparam logic [PWM_BITS-1:0] CNT_LAST    = PWM_BITS'(PERIOD - 1);
   localparam logic [PWM_BITS-1:0] ON_UP_C     = PWM_BITS'(ON_UP);
   localparam logic [PWM_BITS-1:0] ON_DOWN_C   = PWM_BITS'(ON_DOWN);
   localparam logic [PWM_BITS-1:0] ON_CENTER_C = PWM_BITS'(ON_CENTER);

   // Direction code to on-time target; anything unrecognised parks at center.
   function automatic logic [PWM_BITS-1:0] map_dir(input logic [1:0] dir);
      logic [PWM_BITS-1:0] on_time;
      case (dir)
         `SERVO_DIR_UP:   on_time = ON_UP_C;
         `SERVO_DIR_DOWN: on_time = ON_DOWN_C;
         `SERVO_DIR_STAY: on_time = ON_CENTER_C;
         default:         on_time = ON_CENTER_C;
      endcase
      return on_time;
   endfunction

   // Next live on-time at a frame wrap.  With slewing, the distance to the
   // target is formed in PWM_BITS+1 bits and compared with STEP before any
   // add/subtract happens, so the step can never overshoot, wrap or borrow.
   function automatic logic [PWM_BITS-1:0] ramp_next(
      input logic [PWM_BITS-1:0] cur,
      input logic [PWM_BITS-1:0] tgt
   );
      logic [PWM_BITS-1:0] nxt;
`ifdef SERVO_RAMP_EN
      logic [PWM_BITS:0]   dist;
      if (cur < tgt) begin
         dist = {1'b0, tgt} - {1'b0, cur};
         if (32'(dist) <= 32'(STEP)) begin
            nxt = tgt;
         end else begin
            nxt = cur + PWM_BITS'(STEP);
         end
      end else if (cur > tgt) begin
         dist = {1'b0, cur} - {1'b0, tgt};
         if (32'(dist) <= 32'(STEP)) begin
            nxt = tgt;
         end else begin
            nxt = cur - PWM_BITS'(STEP);
         end
      end else begin
         dist = {(PWM_BITS + 1){1'b0}};
         nxt  = cur;
      end
`else
      if (cur == tgt) begin
         nxt = cur;
      end else begin
         nxt = tgt;
      end
`endif
      return nxt;
   endfunction

   logic [PWM_BITS-1:0] cnt_r;
   logic                cmd_ready_r;
   logic                cmd_err_r;
   logic                wrap_s;
   logic                accept_s;
   logic                ch_ok_s;
   logic [PWM_BITS-1:0] new_tgt_s;

   assign wrap_s    = tick && (cnt_r == CNT_LAST);
   assign accept_s  = cmd.cmd_valid && cmd_ready_r;
   assign ch_ok_s   = (32'(cmd.cmd_ch) < 32'(NUM_CH));
   assign new_tgt_s = map_dir(cmd.cmd_dir);

   assign cmd.cmd_ready = cmd_ready_r;
   assign cmd.cmd_err   = cmd_err_r;

   // Frame counter: 0..PERIOD-1, advances on tick, wraps to 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= {PWM_BITS{1'b0}};
      end else if (wrap_s) begin
         cnt_r <= {PWM_BITS{1'b0}};
      end else if (tick) begin
         cnt_r <= cnt_r + {{(PWM_BITS - 1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Ready comes up on the first edge out of reset and then stays high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready_r <= 1'b0;
      end else begin
         cmd_ready_r <= 1'b1;
      end
   end

   // One-cycle error pulse for an accepted command aimed at a missing channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_err_r <= 1'b0;
      end else begin
         cmd_err_r <= accept_s && !ch_ok_s;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PWM_BITS-1:0] tgt_r;
      logic [PWM_BITS-1:0] cur_r;
      logic                pwm_r;
      logic                sel_s;

      assign sel_s = accept_s && ch_ok_s && (cmd.cmd_ch == CH_W'(gi));

      // Target register: written only by an accepted, in-range command.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            tgt_r <= ON_CENTER_C;
         end else if (sel_s) begin
            tgt_r <= new_tgt_s;
         end else begin
            tgt_r <= tgt_r;
         end
      end

      // Live on-time: moves only at a wrap, and always against the target
      // that was in place before this edge (a same-edge command waits a frame).
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cur_r <= ON_CENTER_C;
         end else if (wrap_s) begin
            cur_r <= ramp_next(cur_r, tgt_r);
         end else begin
            cur_r <= cur_r;
         end
      end

      // PWM output: one clock behind the counter; cur=0 is always low and
      // cur=PERIOD is always high.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            pwm_r <= 1'b0;
         end else begin
            pwm_r <= (cnt_r < cur_r);
         end
      end

      assign pwm_out[gi] = pwm_r;
      assign settled[gi] = (cur_r == tgt_r);
   end

   servo_ramp_ctrl_chk #(
      .NUM_CH    (NUM_CH),
      .PWM_BITS  (PWM_BITS),
      .PERIOD    (PERIOD),
      .ON_UP     (ON_UP),
      .ON_DOWN   (ON_DOWN),
      .ON_CENTER (ON_CENTER),
      .STEP      (STEP)
   ) u_chk (
      .clk   (clk),
      .reset (reset)
   );

endmodule

// -----------------------------------------------------------------------------
// servo_ramp_ctrl_chk
//
// Purpose : configuration checker for servo_ramp_ctrl.  Flags parameter sets
//           whose on-time targets exceed the frame or whose sizes are out of
//           range.  Holds no design state.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low reset (checks are idle while low)
// -----------------------------------------------------------------------------
module servo_ramp_ctrl_chk #(
   parameter int NUM_CH    = 2,
   parameter int PWM_BITS  = 8,
   parameter int PERIOD    = 20,
   parameter int ON_UP     = 15,
   parameter int ON_DOWN   = 5,
   parameter int ON_CENTER = 10,
   parameter int STEP      = 1
) (
   input logic clk,
   input logic reset
);

   localparam bit CFG_OK = (ON_UP <= PERIOD) && (ON_DOWN <= PERIOD) &&
                           (ON_CENTER <= PERIOD) && (PERIOD >= 2) &&
                           (PERIOD <= (2 ** PWM_BITS)) && (STEP >= 1) &&
                           (NUM_CH >= 1) && (NUM_CH <= 8);

   cfg_ok_a: assert property (@(posedge clk) disable iff (!reset) CFG_OK);

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servo_ramp_ctrl
//
// Table-driven bench for servo_ramp_ctrl (NUM_CH=2, PERIOD=20, CENTER=10,
// UP=15, DOWN=5, STEP=2, 2-bit channel field).  Each table row is one PWM
// frame: optional reset before it, optional command at a given counter value,
// expected high-time per channel, settled right after the command, settled at
// the end of the frame and number of cmd_err pulses.  Expected values cover
// both builds (SERVO_RAMP_EN defined or not).  Hand-written sequences cover
// reset release, tick stall and reset mid-ramp.
// -----------------------------------------------------------------------------
module tb_servo_ramp_ctrl;

   localparam int NUM_CH    = 2;
   localparam int CH_W      = 2;
   localparam int PWM_BITS  = 8;
   localparam int PERIOD    = 20;
   localparam int ON_UP     = 15;
   localparam int ON_DOWN   = 5;
   localparam int ON_CENTER = 10;
   localparam int STEP      = 2;
   localparam int NROWS     = 18;

   localparam int D_STAY = 0;
   localparam int D_UP   = 1;
   localparam int D_DOWN = 2;

   typedef struct {
      bit rst;
      bit cmd;
      int ch;
      int dir;
      int at;
      int on0;
      int on1;
      int sc;
      int se;
      int err;
   } vec_t;

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic              tick  = 1'b1;
   logic [NUM_CH-1:0] pwm_out;
   logic [NUM_CH-1:0] settled;

   int   n_checks = 0;
   int   n_errors = 0;
   int   tcnt     = 0;
   vec_t tbl[NROWS];

   servo_ramp_ctrl_if #(.CH_W(CH_W)) cmd_if ();

   servo_ramp_ctrl #(
      .NUM_CH    (NUM_CH),
      .CH_W      (CH_W),
      .PWM_BITS  (PWM_BITS),
      .PERIOD    (PERIOD),
      .ON_UP     (ON_UP),
      .ON_DOWN   (ON_DOWN),
      .ON_CENTER (ON_CENTER),
      .STEP      (STEP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .cmd     (cmd_if),
      .pwm_out (pwm_out),
      .settled (settled)
   );

   always #5 clk = ~clk;

   // Reference frame counter, built from tick and reset only.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt <= 0;
      end else if (tick) begin
         tcnt <= (tcnt == PERIOD - 1) ? 0 : tcnt + 1;
      end
   end

   function automatic int pick(input int ramp_val, input int jump_val);
`ifdef SERVO_RAMP_EN
      return ramp_val + 0 * jump_val;
`else
      return jump_val + 0 * ramp_val;
`endif
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_row(input int i, input bit rst, input bit cmd, input int ch,
                          input int dir, input int at, input int on0, input int on1,
                          input int sc, input int se, input int err);
      tbl[i] = '{rst: rst, cmd: cmd, ch: ch, dir: dir, at: at,
                 on0: on0, on1: on1, sc: sc, se: se, err: err};
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Runs one full PWM frame starting at counter 0, optionally issuing a
   // command while the counter equals 'at'.
   task automatic run_period(input bit cmd, input int ch, input int dir, input int at,
                             output int on0, output int on1, output int sc,
                             output int errs);
      int guard;
      guard = 0;
      on0   = 0;
      on1   = 0;
      sc    = 0;
      errs  = 0;
      while (tcnt != 0 && guard < 4 * PERIOD) begin
         @(negedge clk);
         guard++;
      end
      if (tcnt != 0) begin
         chk("frame_sync", tcnt, 0);
      end
      for (int k = 0; k < PERIOD; k++) begin
         if (cmd && k == at) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_ch    = CH_W'(ch);
            cmd_if.cmd_dir   = 2'(dir);
         end
         @(negedge clk);
         on0  += int'(pwm_out[0]);
         on1  += int'(pwm_out[1]);
         errs += int'(cmd_if.cmd_err);
         if (cmd && k == at) begin
            sc = int'(settled);
            cmd_if.cmd_valid = 1'b0;
         end
      end
   endtask

   initial begin
      int on0, on1, sc, errs, guard;

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ch    = '0;
      cmd_if.cmd_dir   = 2'(D_STAY);

      //       i  rst cmd ch dir     at  on0             on1             sc            se            err
      set_row( 0, 0,  0,  0, D_STAY,  0, 10,             10,             0,            3,            0);
      set_row( 1, 0,  0,  0, D_STAY,  0, 10,             10,             0,            3,            0);
      set_row( 2, 0,  1,  0, D_UP,    5, 10,             10,             2,            pick(2, 3),   0);
      set_row( 3, 0,  0,  0, D_STAY,  0, pick(12, 15),   10,             0,            pick(2, 3),   0);
      set_row( 4, 0,  0,  0, D_STAY,  0, pick(14, 15),   10,             0,            3,            0);
      set_row( 5, 0,  0,  0, D_STAY,  0, 15,             10,             0,            3,            0);
      set_row( 6, 1,  1,  0, D_UP,    2, 10,             10,             2,            pick(2, 3),   0);
      set_row( 7, 0,  1,  0, D_DOWN,  7, pick(12, 15),   10,             2,            pick(2, 3),   0);
      set_row( 8, 0,  0,  0, D_STAY,  0, pick(10, 5),    10,             0,            pick(2, 3),   0);
      set_row( 9, 0,  0,  0, D_STAY,  0, pick(8, 5),     10,             0,            pick(2, 3),   0);
      set_row(10, 0,  0,  0, D_STAY,  0, pick(6, 5),     10,             0,            3,            0);
      set_row(11, 0,  0,  0, D_STAY,  0, 5,              10,             0,            3,            0);
      set_row(12, 0,  1,  1, D_UP,   19, 5,              10,             1,            1,            0);
      set_row(13, 0,  0,  0, D_STAY,  0, 5,              10,             0,            pick(1, 3),   0);
      set_row(14, 0,  0,  0, D_STAY,  0, 5,              pick(12, 15),   0,            pick(1, 3),   0);
      set_row(15, 0,  1,  2, D_UP,    4, 5,              pick(14, 15),   pick(1, 3),   3,            1);
      set_row(16, 0,  1,  3, D_DOWN,  9, 5,              15,             3,            3,            1);
      set_row(17, 0,  0,  0, D_STAY,  0, 5,              15,             0,            3,            0);

      // Reset state and reset release.
      repeat (2) @(negedge clk);
      chk("rst_ready",   int'(cmd_if.cmd_ready), 0);
      chk("rst_pwm",     int'(pwm_out), 0);
      chk("rst_settled", int'(settled), 3);
      chk("rst_err",     int'(cmd_if.cmd_err), 0);
      reset = 1'b1;
      #1;
      chk("release_ready_0", int'(cmd_if.cmd_ready), 0);
      @(negedge clk);
      chk("release_ready_1", int'(cmd_if.cmd_ready), 1);

      for (int i = 0; i < NROWS; i++) begin
         if (tbl[i].rst) begin
            do_reset();
         end
         run_period(tbl[i].cmd, tbl[i].ch, tbl[i].dir, tbl[i].at, on0, on1, sc, errs);
         chk($sformatf("row%0d_on0", i), on0, tbl[i].on0);
         chk($sformatf("row%0d_on1", i), on1, tbl[i].on1);
         chk($sformatf("row%0d_settled_end", i), int'(settled), tbl[i].se);
         chk($sformatf("row%0d_err_pulses", i), errs, tbl[i].err);
         if (tbl[i].cmd) begin
            chk($sformatf("row%0d_settled_cmd", i), sc, tbl[i].sc);
         end
      end

      // Tick stall at counter 7: outputs hold, a command is still taken.
      guard = 0;
      while (tcnt != 7 && guard < 4 * PERIOD) begin
         @(negedge clk);
         guard++;
      end
      chk("stall_sync", tcnt, 7);
      tick = 1'b0;
      for (int j = 0; j < 5; j++) begin
         if (j == 1) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_ch    = CH_W'(0);
            cmd_if.cmd_dir   = 2'(D_UP);
         end
         @(negedge clk);
         chk($sformatf("stall_pwm_%0d", j), int'(pwm_out), 2);
         if (j == 1) begin
            chk("stall_settled", int'(settled), 2);
            cmd_if.cmd_valid = 1'b0;
         end
      end
      tick = 1'b1;
      run_period(1'b0, 0, D_STAY, 0, on0, on1, sc, errs);
      chk("after_stall_on0", on0, pick(7, 15));
      chk("after_stall_on1", on1, 15);

      // Reset asserted mid-ramp (cur0 = 14 with slewing).
      do_reset();
      run_period(1'b1, 0, D_UP, 3, on0, on1, sc, errs);
      chk("mr_on0_a", on0, 10);
      run_period(1'b0, 0, D_STAY, 0, on0, on1, sc, errs);
      chk("mr_on0_b", on0, pick(12, 15));
      repeat (3) @(negedge clk);
      chk("mr_pwm_before", int'(pwm_out), 3);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_pwm_in_reset",     int'(pwm_out), 0);
      chk("mr_ready_in_reset",   int'(cmd_if.cmd_ready), 0);
      chk("mr_settled_in_reset", int'(settled), 3);
      chk("mr_err_in_reset",     int'(cmd_if.cmd_err), 0);
      @(negedge clk);
      reset = 1'b1;
      run_period(1'b0, 0, D_STAY, 0, on0, on1, sc, errs);
      chk("mr_on0_after", on0, 10);
      chk("mr_on1_after", on1, 10);
      chk("mr_settled_after", int'(settled), 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
